// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: ALU control codes and MDU op/state encodings.
package mips_pkg;

  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;

  typedef enum logic [1:0] {
    MULTU = 2'b00,
    DIVU  = 2'b01,
    MULT  = 2'b10,
    DIV   = 2'b11
  } mdu_op_t;

  typedef enum logic [2:0] {
    IDLE,
    PREP,
    ITER,
    FIX,
    DONE
  } mdu_state_t;

endpackage

// File: rtl/mdu_sequencer.sv
// Multi-cycle shift-add multiply / restoring divide using the shared ALU one op per cycle.
// Signed MULT/DIV are built in only when MDU_SIGNED_EN is defined.
module mdu_sequencer
  import mips_pkg::*;
#(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] opa,
  input  logic [WIDTH-1:0] opb,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             div_by_zero,
  output logic             alu_req,
  input  logic             alu_gnt,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [3:0]       alu_ctrl,
  input  logic [WIDTH-1:0] alu_result
);

  localparam logic [WIDTH-1:0] Zero = '0;

  mdu_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div_q, is_div_d;
  // acc_hi holds P_hi / R, acc_lo holds P_lo / Q, m holds M / D.
  logic [WIDTH-1:0] acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0] acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0] m_q, m_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             dbz_q, dbz_d;

  mdu_op_t op_e;
  logic    start_div;
  assign op_e      = mdu_op_t'(op);
  assign start_div = (op_e == DIVU) || (op_e == DIV);

  logic [WIDTH-1:0] mul_sum, div_rs, it_hi, it_lo;
  logic             mul_carry, div_q;
  assign mul_sum   = acc_lo_q[0] ? alu_result : acc_hi_q;
  assign mul_carry = acc_lo_q[0] & (alu_result < acc_hi_q);
  assign div_rs    = {acc_hi_q[WIDTH-2:0], acc_lo_q[WIDTH-1]};
  assign div_q     = acc_hi_q[WIDTH-1] | (div_rs >= m_q);
  assign it_hi     = is_div_q ? (div_q ? alu_result : div_rs) : {mul_carry, mul_sum[WIDTH-1:1]};
  assign it_lo     = is_div_q ? {acc_lo_q[WIDTH-2:0], div_q} : {mul_sum[0], acc_lo_q[WIDTH-1:1]};

`ifdef MDU_SIGNED_EN
  logic                 sgn_q, sgn_d;
  logic                 neg_res_q, neg_res_d;
  logic                 neg_rem_q, neg_rem_d;
  logic                 start_sgn;
  logic [WIDTH-1:0]     abs_lo, abs_m;
  logic [2*WIDTH-1:0]   prod_neg;
  assign start_sgn = (op_e == MULT) || (op_e == DIV);
  assign abs_lo    = acc_lo_q[WIDTH-1] ? (Zero - acc_lo_q) : acc_lo_q;
  assign abs_m     = m_q[WIDTH-1] ? (Zero - m_q) : m_q;
  assign prod_neg  = {2*WIDTH{1'b0}} - {acc_hi_q, acc_lo_q};
`endif

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    is_div_d = is_div_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    m_d      = m_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    dbz_d    = dbz_q;
`ifdef MDU_SIGNED_EN
    sgn_d     = sgn_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (start) begin
          is_div_d = start_div;
          cnt_d    = '0;
          if (start_div && (opb == Zero)) begin
            hi_d    = opa;
            lo_d    = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            acc_hi_d = '0;
            acc_lo_d = start_div ? opa : opb;
            m_d      = start_div ? opb : opa;
            state_d  = ITER;
`ifdef MDU_SIGNED_EN
            sgn_d     = start_sgn;
            neg_res_d = opa[WIDTH-1] ^ opb[WIDTH-1];
            neg_rem_d = opa[WIDTH-1];
            if (start_sgn) state_d = PREP;
`endif
          end
        end
      end
`ifdef MDU_SIGNED_EN
      PREP: begin
        acc_lo_d = abs_lo;
        m_d      = abs_m;
        state_d  = ITER;
      end
      FIX: begin
        if (is_div_q) begin
          lo_d = neg_res_q ? (Zero - acc_lo_q) : acc_lo_q;
          hi_d = neg_rem_q ? (Zero - acc_hi_q) : acc_hi_q;
        end else begin
          {hi_d, lo_d} = neg_res_q ? prod_neg : {acc_hi_q, acc_lo_q};
        end
        dbz_d   = 1'b0;
        state_d = DONE;
      end
`endif
      ITER: begin
        if (alu_gnt) begin
          acc_hi_d = it_hi;
          acc_lo_d = it_lo;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(WIDTH - 1)) begin
            hi_d    = it_hi;
            lo_d    = it_lo;
            dbz_d   = 1'b0;
            state_d = DONE;
`ifdef MDU_SIGNED_EN
            // Signed ops leave hi/lo alone here; FIX loads the corrected result.
            if (sgn_q) begin
              hi_d    = hi_q;
              lo_d    = lo_q;
              dbz_d   = dbz_q;
              state_d = FIX;
            end
`endif
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      is_div_q <= 1'b0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      m_q      <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      dbz_q    <= 1'b0;
`ifdef MDU_SIGNED_EN
      sgn_q     <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      is_div_q <= is_div_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      m_q      <= m_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      dbz_q    <= dbz_d;
`ifdef MDU_SIGNED_EN
      sgn_q     <= sgn_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
`endif
    end
  end

  always_comb begin
    alu_req  = 1'b0;
    alu_a    = '0;
    alu_b    = '0;
    alu_ctrl = 4'b0000;
    if (state_q == ITER) begin
      alu_req  = 1'b1;
      alu_a    = is_div_q ? div_rs : acc_hi_q;
      alu_b    = m_q;
      alu_ctrl = is_div_q ? ALU_SUB : ALU_ADD;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign hi          = hi_q;
  assign lo          = lo_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_mdu_sequencer.sv
// Directed self-checking bench for mdu_sequencer with a behavioural shared ALU.
module tb_mdu_sequencer;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, alu_gnt;
  logic [1:0]  op;
  logic [31:0] opa, opb, hi, lo, alu_a, alu_b, alu_result;
  logic        busy, done, div_by_zero, alu_req;
  logic [3:0]  alu_ctrl;

  int n_cmp = 0;
  int n_mis = 0;

  always #5 clk = ~clk;

  assign alu_result = (alu_ctrl == ALU_SUB) ? alu_a - alu_b : alu_a + alu_b;

  mdu_sequencer #(.WIDTH(32), .CNT_W(6)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .opa(opa), .opb(opb),
    .busy(busy), .done(done), .hi(hi), .lo(lo), .div_by_zero(div_by_zero),
    .alu_req(alu_req), .alu_gnt(alu_gnt), .alu_a(alu_a), .alu_b(alu_b),
    .alu_ctrl(alu_ctrl), .alu_result(alu_result)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Launch one op at a negedge and watch it to done; returns cycles from the start cycle.
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input bit toggle, input logic [3:0] exp_ctrl,
                        output int lat, output int grants, output bit ctrl_ok,
                        output bit req_seen, output bit stable_ok);
    bit          prev_wait;
    logic [31:0] pa, pb;
    op = o; opa = a; opb = b; start = 1'b1; alu_gnt = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    lat = 0; grants = 0; ctrl_ok = 1'b1; req_seen = 1'b0; stable_ok = 1'b1;
    prev_wait = 1'b0; pa = '0; pb = '0;
    while (lat < 200) begin
      @(negedge clk);
      lat++;
      if (toggle) alu_gnt = ~alu_gnt;
      if (alu_req) req_seen = 1'b1;
      if (alu_req && alu_ctrl != exp_ctrl) ctrl_ok = 1'b0;
      if (prev_wait && (alu_a != pa || alu_b != pb)) stable_ok = 1'b0;
      prev_wait = alu_req && !alu_gnt;
      pa = alu_a; pb = alu_b;
      if (alu_req && alu_gnt) grants++;
      if (done) break;
    end
    alu_gnt = 1'b1;
  endtask

  int lat, grants;
  bit ctrl_ok, req_seen, stable_ok;

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; opa = '0; opb = '0; alu_gnt = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_done", done, 0);
    check_eq("rst_dbz", div_by_zero, 0);
    check_eq("rst_req", alu_req, 0);
    check_eq("rst_alu", {alu_a, alu_b}, 0);
    check_eq("rst_ctrl", alu_ctrl, 0);
    check_eq("rst_hilo", {hi, lo}, 0);
    reset = 1'b0;
    @(negedge clk);

    // 1: MULTU 3*2
    run_op(2'b00, 32'd3, 32'd2, 1'b0, ALU_ADD, lat, grants, ctrl_ok, req_seen, stable_ok);
    check_eq("mul1_lat", lat, 33);
    check_eq("mul1_hilo", {hi, lo}, 64'd6);
    check_eq("mul1_ctrl", ctrl_ok, 1);
    check_eq("mul1_dbz", div_by_zero, 0);
    @(negedge clk);
    check_eq("mul1_idle", busy, 0);

    // 2: MULTU max*max, carry path
    run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, ALU_ADD, lat, grants, ctrl_ok,
           req_seen, stable_ok);
    check_eq("mul2_lat", lat, 33);
    check_eq("mul2_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    @(negedge clk);

    // 3: DIVU 26/15, a start in the done cycle is dropped, then DIVU 10/10
    run_op(2'b01, 32'd26, 32'd15, 1'b0, ALU_SUB, lat, grants, ctrl_ok, req_seen, stable_ok);
    check_eq("div1_lat", lat, 33);
    check_eq("div1_hilo", {hi, lo}, {32'd11, 32'd1});
    check_eq("div1_ctrl", ctrl_ok, 1);
    op = 2'b01; opa = 32'd10; opb = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(negedge clk);
    check_eq("div1_ign_busy", busy, 0);
    check_eq("div1_hold", {hi, lo, 31'd0, div_by_zero}, {32'd11, 32'd1, 32'd0});
    run_op(2'b01, 32'd10, 32'd10, 1'b0, ALU_SUB, lat, grants, ctrl_ok, req_seen, stable_ok);
    check_eq("div2_lat", lat, 33);
    check_eq("div2_hilo", {hi, lo}, {32'd0, 32'd1});
    @(negedge clk);

    // 4: DIVU by zero
    run_op(2'b01, 32'd5, 32'd0, 1'b0, ALU_SUB, lat, grants, ctrl_ok, req_seen, stable_ok);
    check_eq("dbz_lat", lat, 1);
    check_eq("dbz_flag", div_by_zero, 1);
    check_eq("dbz_hilo", {hi, lo}, {32'd5, 32'hFFFF_FFFF});
    check_eq("dbz_noreq", req_seen, 0);
    @(negedge clk);

    // 5: MULTU 5*7 with a toggling grant
    run_op(2'b00, 32'd5, 32'd7, 1'b1, ALU_ADD, lat, grants, ctrl_ok, req_seen, stable_ok);
    check_eq("gnt_hilo", {hi, lo}, 64'd35);
    check_eq("gnt_count", grants, 32);
    check_eq("gnt_stable", stable_ok, 1);
    check_eq("gnt_dbz_clr", div_by_zero, 0);
    @(negedge clk);

    // 6: start while busy is ignored, then reset mid-ITER
    op = 2'b00; opa = 32'd9; opb = 32'd9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(negedge clk);
    op = 2'b01; opa = 32'd1; opb = 32'd0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (5) @(negedge clk);
    check_eq("busy_ign_req", {busy, alu_req, done}, 3'b110);
    check_eq("busy_ign_ctrl", alu_ctrl, ALU_ADD);
    reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_req", alu_req, 0);
    check_eq("abort_hilo", {hi, lo}, 0);

`ifdef MDU_SIGNED_EN
    run_op(2'b10, 32'hFFFF_FFFD, 32'd2, 1'b0, ALU_ADD, lat, grants, ctrl_ok, req_seen,
           stable_ok);
    check_eq("mult_lat", lat, 35);
    check_eq("mult_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
    @(negedge clk);
    run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0, ALU_SUB, lat, grants, ctrl_ok, req_seen,
           stable_ok);
    check_eq("sdiv_lat", lat, 35);
    check_eq("sdiv_hilo", {hi, lo}, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    @(negedge clk);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/mdu_sequencer.md
Name: mdu_sequencer

Overview:
Multi-cycle multiply/divide unit for the MIPS core (MULTU/DIVU, plus MULT/DIV when the optional feature is built in). It implements shift-add multiply and restoring divide by issuing one add or subtract per cycle to the shared 32-bit ALU, through a request/grant handshake. It produces the HI/LO results and pulses done.

Parameters:
WIDTH, 32, operand/result width; only 32 is supported.
CNT_W, 6, iteration counter width; must satisfy 2**CNT_W > WIDTH.

Ports:
clk  input  1  clock; all logic is rising-edge.
reset  input  1  synchronous, active-high reset.
start  input  1  launch an operation; sampled only in IDLE.
op  input  2  00=MULTU, 01=DIVU, 10=MULT, 11=DIV.
opa  input  32  multiplicand / dividend.
opb  input  32  multiplier / divisor.
busy  output  1  high in every state except IDLE.
done  output  1  one-cycle pulse; hi/lo are valid in the same cycle.
hi  output  32  product[63:32] or remainder.
lo  output  32  product[31:0] or quotient.
div_by_zero  output  1  valid with done; set when a divide has opb==0.
alu_req  output  1  requests the shared ALU for the current cycle.
alu_gnt  input  1  ALU granted this cycle; combinational from the arbiter.
alu_a  output  32  drives the ALU scrA operand.
alu_b  output  32  drives the ALU scrB operand.
alu_ctrl  output  4  drives ALUControl; 4'b0010 = add, 4'b0110 = sub.
alu_result  input  32  ALUResult, returned in the same cycle.

Behaviour:
- Reset (synchronous, active-high) forces:
  - state IDLE;
  - busy=0, done=0, div_by_zero=0, alu_req=0;
  - alu_a=0, alu_b=0, alu_ctrl=0, hi=0, lo=0.
- Reset asserted mid-operation aborts the operation; hi/lo are cleared on the next edge.
- States: IDLE -> [PREP] -> ITER -> [FIX] -> DONE -> IDLE. PREP and FIX exist only for signed ops with the macro enabled.
- IDLE:
  - start=1 latches op, opa and opb.
  - Unsigned ops go to ITER with count=0.
  - DIVU with opb==0 goes straight to DONE.
  - start is ignored whenever busy=1.
- ITER:
  - alu_req=1.
  - State, counter and partial registers advance only on cycles with alu_gnt=1; otherwise everything holds.
  - alu_a, alu_b and alu_ctrl stay stable while waiting for a grant.
  - After the 32nd granted iteration, go to DONE (or FIX).
- Outside ITER: alu_req=0 and alu_a/alu_b/alu_ctrl are driven to 0.
- Multiply (P_hi=0, P_lo=opb, M=opa); each iteration:
  - drive alu_a=P_hi, alu_b=M, ctrl=add;
  - if P_lo[0]=1: sum=alu_result, carry=(alu_result < P_hi) unsigned compare; else sum=P_hi, carry=0;
  - update {P_hi,P_lo} <= {carry, sum, P_lo[31:1]}.
- Divide (R=0, Q=opa, D=opb); each iteration:
  - form {msb, Rs} = {R, Q[31]};
  - drive alu_a=Rs, alu_b=D, ctrl=sub;
  - q = msb | (Rs >= D) unsigned compare;
  - R <= q ? alu_result : Rs;
  - Q <= {Q[30:0], q}.
- DONE (one cycle):
  - done=1;
  - hi/lo registered as P_hi/P_lo (multiply) or R/Q (divide);
  - on divide by zero: hi=opa, lo=32'hFFFF_FFFF, div_by_zero=1.
- hi, lo and div_by_zero hold their values until the next DONE.
- Latency with alu_gnt tied high, start accepted at edge k:
  - unsigned: done in cycle k+33;
  - divide by zero: done in cycle k+1;
  - signed: done in cycle k+35.
- A start arriving in the done cycle is ignored; the block returns to IDLE on the following edge.

Optional Feature:
MDU_SIGNED_EN
- Defined:
  - op[1]=1 selects signed operation.
  - PREP takes the absolute values of opa and opb locally (no ALU use) and records both signs.
  - FIX negates locally: the 64-bit product if the signs differ; the quotient if the signs differ; the remainder takes the sign of the dividend (truncating division).
  - Signed divide by zero follows the unsigned divide-by-zero rule.
- Undefined: op[1] is ignored; MULT/DIV execute as MULTU/DIVU; no PREP or FIX states exist.

Decomposition:
- Shared package mips_pkg holds:
  - ALU_ADD=4'b0010, ALU_SUB=4'b0110;
  - mdu_op_t enum (MULTU, DIVU, MULT, DIV);
  - mdu_state_t enum (IDLE, PREP, ITER, FIX, DONE).
- No sub-module: a single module, with the shared ALU external via the alu_* ports.

Test Plan:
1. MULTU opa=3, opb=2, alu_gnt=1 -> done exactly 33 cycles after start; hi=0, lo=6; alu_ctrl=4'b0010 throughout ITER.
2. MULTU opa=opb=32'hFFFFFFFF -> hi=32'hFFFFFFFE, lo=32'h00000001 (exercises the carry path).
3. DIVU 26/15 -> lo=1, hi=11; then DIVU 10/10 -> lo=1, hi=0; back-to-back starts are accepted only in IDLE.
4. DIVU opa=5, opb=0 -> done in the next cycle; div_by_zero=1, hi=5, lo=32'hFFFFFFFF; alu_req never asserted.
5. MULTU 5x7 with alu_gnt toggling every cycle -> lo=35 after exactly 32 granted cycles; alu_a/alu_b stable across denied cycles.
6. Reset asserted at ITER cycle 10 -> next cycle busy=0, alu_req=0, hi=lo=0; a start pulse while busy is ignored.
   With MDU_SIGNED_EN defined:
   - MULT -3x2 -> hi=32'hFFFFFFFF, lo=32'hFFFFFFFA;
   - DIV -7/2 -> lo=32'hFFFFFFFD, hi=32'hFFFFFFFF;
   - done at cycle k+35.
